mem_bus_ctrl: RTL and testbench

Sequencer for the shared bidirectional main-memory data bus. It arbitrates single-word load/store requests from two requesters: requester 0 is the core and requester 1 is the test/boot loader. It drives address, write data and the pad direction enable for the bidirectional data pads, and inserts turnaround cycles whenever the bus direction changes so the pads and external memory never drive the bus together. It sits between the core and the pad ring.

---
 rtl/mem_bus_pkg.sv | 24 ++
 rtl/mem_bus_arb.sv | 34 +++
 rtl/mem_bus_ctrl.sv | 141 ++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the main-memory bus sequencer.
package mem_bus_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  typedef enum logic [1:0] {IDLE, TURN, WRITE, READ} state_e;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_DATA_W-1:0] rdata;
  } mem_rsp_t;

endpackage

// File: rtl/mem_bus_arb.sv
// Two-way request arbiter. MEM_BUS_CTRL_RR_EN selects round-robin;
// otherwise requester 0 has fixed priority and no pointer exists.
module mem_bus_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       adv,
  output logic [1:0] grant
);

`ifdef MEM_BUS_CTRL_RR_EN
  logic ptr;

  always_comb begin
    grant = valid;
    if (&valid) begin
      grant      = 2'b00;
      grant[ptr] = 1'b1;
    end
  end

  // Pointer only moves on a contested accept, toward the loser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 ptr <= 1'b0;
    else if (adv && &valid)  ptr <= ~ptr;
  end
`else
  assign grant = {valid[1] & ~valid[0], valid[0]};

  logic unused_rr;
  assign unused_rr = ^{clk, rst, adv};
`endif

endmodule

// File: rtl/mem_bus_ctrl.sv
// Shared bidirectional memory bus sequencer with direction turnaround.
// Arbitration mode set by MEM_BUS_CTRL_RR_EN (see mem_bus_arb).
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int TURN_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int CNT_MAX = (RD_LAT > TURN_CYC) ? RD_LAT : TURN_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state;
  logic              last_dir;
  logic              owner;
  logic              cur_we;
  logic [CNT_W-1:0]  cnt;

  logic [1:0]        vld, gnt;
  logic              idle, acc, win;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;

  assign vld        = {req1_valid, req0_valid};
  assign idle       = (state == IDLE);
  assign req0_ready = idle & gnt[0];
  assign req1_ready = idle & gnt[1];
  assign acc        = idle & |(vld & gnt);
  assign win        = gnt[1];
  assign a_we       = win ? req1_we    : req0_we;
  assign a_addr     = win ? req1_addr  : req0_addr;
  assign a_wdata    = win ? req1_wdata : req0_wdata;

  mem_bus_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (vld),
    .adv   (acc),
    .grant (gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_dir   <= DIR_READ;
      owner      <= 1'b0;
      cur_we     <= DIR_READ;
      cnt        <= '0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          owner    <= win;
          cur_we   <= a_we;
          bus_addr <= a_addr;
          if (a_we) bus_wdata <= a_wdata;
          // Pads and memory must never overlap: idle the bus on a flip.
          if (a_we != last_dir) begin
            state <= TURN;
            cnt   <= CNT_W'(TURN_CYC - 1);
          end else if (a_we) begin
            state  <= WRITE;
            bus_we <= 1'b1;
          end else begin
            state <= READ;
            cnt   <= CNT_W'(RD_LAT - 1);
          end
        end
        TURN: begin
          if (cnt == '0) begin
            if (cur_we) begin
              state  <= WRITE;
              bus_we <= 1'b1;
            end else begin
              state <= READ;
              cnt   <= CNT_W'(RD_LAT - 1);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WRITE: begin
          bus_we   <= 1'b0;
          last_dir <= DIR_WRITE;
          state    <= IDLE;
          if (owner) rsp1_valid <= 1'b1;
          else       rsp0_valid <= 1'b1;
        end
        READ: begin
          if (cnt == '0) begin
            last_dir <= DIR_READ;
            state    <= IDLE;
            if (owner) begin
              rsp1_valid <= 1'b1;
              rsp1_rdata <= bus_rdata;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_rdata <= bus_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed vector bench for mem_bus_ctrl (RD_LAT=1 and RD_LAT=3 instances).
module tb_mem_bus_ctrl;
  import mem_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance: RD_LAT=1, TURN_CYC=1
  logic        req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
  logic [7:0]  req0_addr = 0, req1_addr = 0;
  logic [15:0] req0_wdata = 0, req1_wdata = 0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, bus_we;
  logic [15:0] rsp0_rdata, rsp1_rdata, bus_wdata, bus_rdata;
  logic [7:0]  bus_addr;

  mem_bus_ctrl #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .TURN_CYC(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata)
  );

  // Second instance: RD_LAT=3; read data is a cycle stamp
  logic        l3_req0_valid = 0, l3_req0_we = 0, l3_req1_valid = 0, l3_req1_we = 0;
  logic [7:0]  l3_req0_addr = 0, l3_req1_addr = 0;
  logic [15:0] l3_req0_wdata = 0, l3_req1_wdata = 0;
  logic        l3_req0_ready, l3_req1_ready, l3_rsp0_valid, l3_rsp1_valid, l3_bus_we;
  logic [15:0] l3_rsp0_rdata, l3_rsp1_rdata, l3_bus_wdata, l3_bus_rdata;
  logic [7:0]  l3_bus_addr;

  assign l3_bus_rdata = {8'hA0, cyc[7:0]};

  mem_bus_ctrl #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3), .TURN_CYC(1)) dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(l3_req0_valid), .req0_we(l3_req0_we), .req0_addr(l3_req0_addr),
    .req0_wdata(l3_req0_wdata), .req0_ready(l3_req0_ready),
    .req1_valid(l3_req1_valid), .req1_we(l3_req1_we), .req1_addr(l3_req1_addr),
    .req1_wdata(l3_req1_wdata), .req1_ready(l3_req1_ready),
    .rsp0_valid(l3_rsp0_valid), .rsp0_rdata(l3_rsp0_rdata),
    .rsp1_valid(l3_rsp1_valid), .rsp1_rdata(l3_rsp1_rdata),
    .bus_we(l3_bus_we), .bus_addr(l3_bus_addr), .bus_wdata(l3_bus_wdata),
    .bus_rdata(l3_bus_rdata)
  );

  // External memory and the bench's own expectation of its contents
  logic [15:0] mem     [256];
  logic [15:0] exp_mem [256];
  assign bus_rdata = mem[bus_addr];
  always @(posedge clk) if (bus_we) mem[bus_addr] <= bus_wdata;

  int nvec = 0, nerr = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Memory drives the bus during READ; pads must not drive the next cycle
  logic prev_read;
  int   contention = 0;
  always @(posedge clk or posedge rst)
    if (rst) prev_read <= 1'b0;
    else     prev_read <= (dut.state == READ);
  always @(negedge clk)
    if (!rst && prev_read && bus_we) begin
      contention++;
      $display("FAIL contention: bus_we=1 right after read cycle %0d", cyc);
    end

  logic model_dir = DIR_READ;
  int   last_acc  = 0;

  task automatic req_set(input bit id, input bit v, input bit we,
                         input logic [7:0] a, input logic [15:0] d);
    if (id) begin req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; end
    else    begin req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; end
  endtask

  task automatic txn(input string nm, input bit id, input bit we, input logic [7:0] a,
                     input logic [15:0] d, input int lat, input logic [15:0] rd, input int gap);
    int n, acc_c, wcnt, other;
    bit ok;
    req_set(id, 1'b1, we, a, d);
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, ".accept"}, id ? req1_ready : req0_ready, 1);
    acc_c = cyc;
    if (gap > 0) chk({nm, ".gap"}, acc_c - last_acc, gap);
    last_acc = acc_c;
    @(negedge clk);
    req_set(id, 1'b0, we, a, d);
    wcnt = 0; other = 0; ok = 0; n = 0;
    while (!ok && n < 20) begin
      #1;
      if (bus_we) begin
        wcnt++;
        if (we) begin
          chk({nm, ".waddr"}, bus_addr, a);
          chk({nm, ".wdata"}, bus_wdata, d);
        end
      end
      if (id ? rsp0_valid : rsp1_valid) other++;
      if (id ? rsp1_valid : rsp0_valid) ok = 1;
      else begin @(negedge clk); n++; end
    end
    chk({nm, ".rsp"}, ok, 1);
    chk({nm, ".lat"}, cyc - acc_c, lat);
    chk({nm, ".we_cycles"}, wcnt, we ? 1 : 0);
    chk({nm, ".other_rsp"}, other, 0);
    if (!we) chk({nm, ".rdata"}, id ? rsp1_rdata : rsp0_rdata, rd);
    if (we) exp_mem[a] = d;
    model_dir = we;
  endtask

  task automatic txn3(input string nm, input bit we, input logic [7:0] a, input int lat);
    int n, acc_c;
    bit ok;
    l3_req0_valid = 1; l3_req0_we = we; l3_req0_addr = a; l3_req0_wdata = 16'h3C3C;
    #1;
    n = 0;
    while (!l3_req0_ready && n < 20) begin @(negedge clk); #1; n++; end
    chk({nm, ".accept"}, l3_req0_ready, 1);
    acc_c = cyc;
    @(negedge clk);
    l3_req0_valid = 0;
    ok = 0; n = 0;
    while (!ok && n < 20) begin
      #1;
      if (l3_rsp0_valid) ok = 1;
      else begin @(negedge clk); n++; end
    end
    chk({nm, ".rsp"}, ok, 1);
    chk({nm, ".lat"}, cyc - acc_c, lat);
    // Data must be the stamp of the last address-drive cycle
    if (!we) chk({nm, ".rdata"}, l3_rsp0_rdata, {8'hA0, 8'(acc_c + lat - 1)});
  endtask

  typedef struct {
    bit          id;
    bit          we;
    logic [7:0]  a;
    logic [15:0] d;
    int          lat;
    logic [15:0] rd;
    int          gap;
  } vec_t;

  vec_t tbl[11];
  int   order[4];
  int   exp_order[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, n, c0, c1, pulses;
    bit we;
    logic [7:0] a;
    logic [15:0] d;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'h5A00 ^ 16'(i);
      exp_mem[i] = 16'h5A00 ^ 16'(i);
    end

    tbl[0]  = '{1'b0, 1'b1, 8'h12, 16'hBEEF, 3, 16'h0000, 0};
    tbl[1]  = '{1'b0, 1'b0, 8'h12, 16'h0000, 3, 16'hBEEF, 3};
    tbl[2]  = '{1'b1, 1'b0, 8'h01, 16'h0000, 2, 16'h5A01, 3};
    tbl[3]  = '{1'b1, 1'b0, 8'h02, 16'h0000, 2, 16'h5A02, 2};
    tbl[4]  = '{1'b1, 1'b1, 8'h02, 16'h1234, 3, 16'h0000, 2};
    tbl[5]  = '{1'b0, 1'b1, 8'h03, 16'hABCD, 2, 16'h0000, 3};
    tbl[6]  = '{1'b1, 1'b0, 8'h03, 16'h0000, 3, 16'hABCD, 2};
    tbl[7]  = '{1'b0, 1'b0, 8'h02, 16'h0000, 2, 16'h1234, 3};
    tbl[8]  = '{1'b0, 1'b0, 8'hFF, 16'h0000, 2, 16'h5AFF, 2};
    tbl[9]  = '{1'b1, 1'b1, 8'h00, 16'hFFFF, 3, 16'h0000, 2};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 16'h0000, 3, 16'hFFFF, 3};

`ifdef MEM_BUS_CTRL_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 1, 1};
`endif

    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("reset.bus_we", bus_we, 0);
    chk("reset.bus_addr", bus_addr, 0);
    chk("reset.bus_wdata", bus_wdata, 0);
    chk("reset.rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    chk("reset.rsp0_rdata", rsp0_rdata, 0);
    chk("reset.rsp1_rdata", rsp1_rdata, 0);
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      txn($sformatf("v%0d", i), tbl[i].id, tbl[i].we, tbl[i].a, tbl[i].d,
          tbl[i].lat, tbl[i].rd, tbl[i].gap);

    // Both requesters contend for four reads
    req_set(1'b0, 1'b1, 1'b0, 8'h10, 16'h0);
    req_set(1'b1, 1'b1, 1'b0, 8'h20, 16'h0);
    g = 0; n = 0; c0 = 0; c1 = 0;
    while (g < 4 && n < 60) begin
      #1;
      if (req0_valid && req0_ready) begin order[g] = 0; g++; c0++; end
      else if (req1_valid && req1_ready) begin order[g] = 1; g++; c1++; end
      @(negedge clk); n++;
      if (c0 == 2) req0_valid = 0;
      if (c1 == 2) req1_valid = 0;
    end
    req0_valid = 0; req1_valid = 0;
    chk("arb.grants", g, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("arb.order%0d", i), order[i], exp_order[i]);
    repeat (4) @(negedge clk);

    // Reset while the write strobe is asserted
    req_set(1'b0, 1'b1, 1'b1, 8'h40, 16'h7777);
    n = 0;
    #1;
    while (!bus_we && n < 20) begin
      @(negedge clk);
      req0_valid = req0_valid & ~(dut.state != IDLE);
      #1; n++;
    end
    req0_valid = 0;
    chk("rstw.strobe_seen", bus_we, 1);
    rst = 1;
    #1;
    chk("rstw.bus_we", bus_we, 0);
    chk("rstw.bus_addr", bus_addr, 0);
    chk("rstw.bus_wdata", bus_wdata, 0);
    chk("rstw.rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    chk("rstw.rdata", {rsp1_rdata, rsp0_rdata}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) pulses++;
    end
    chk("rstw.no_rsp", pulses, 0);
    model_dir = DIR_READ;
    txn("rstw.read", 1'b0, 1'b0, 8'h40, 16'h0, 2, 16'h5A40, 0);

    // Random mixed traffic on a small address window
    for (int i = 0; i < 24; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 7));
      d  = 16'($urandom);
      txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), we, a, d,
          2 + ((we != model_dir) ? 1 : 0), exp_mem[a], 0);
    end

    // Longer read latency instance
    @(negedge clk);
    txn3("l3.rd0", 1'b0, 8'h05, 4);
    txn3("l3.rd1", 1'b0, 8'h06, 4);
    txn3("l3.wr",  1'b1, 8'h07, 3);
    txn3("l3.rd2", 1'b0, 8'h07, 5);

    chk("no_contention", contention, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
